// File: rtl/ripple_sampler_pkg.sv
// Shared types and default sizing for the ripple counter sampler.
package ripple_sampler_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    TRACK   = 2'd2
  } state_t;

  localparam int WIDTH_DEF      = 4;
  localparam int STABLE_CYC_DEF = 2;
  localparam int WRAP_W_DEF     = 8;
  localparam int ERR_CNT_W      = 8;

endpackage

// File: rtl/ripple_count_sampler_if.sv
// Enable/sample inputs and accepted-count outputs of the ripple counter sampler.
interface ripple_count_sampler_if #(
  parameter int WIDTH  = 4,
  parameter int WRAP_W = 8
);
  import ripple_sampler_pkg::*;

  logic                     en;
  logic [WIDTH-1:0]         q_in;
  logic [WIDTH-1:0]         count;
  logic                     count_valid;
  logic [WRAP_W+WIDTH-1:0]  ext_count;
  logic                     wrap_pulse;
  logic                     step_err;
  logic [ERR_CNT_W-1:0]     err_cnt;

  modport master (
    output en, q_in,
    input  count, count_valid, ext_count, wrap_pulse, step_err, err_cnt
  );

  modport slave (
    input  en, q_in,
    output count, count_valid, ext_count, wrap_pulse, step_err, err_cnt
  );
endinterface

// File: rtl/count_bus_sync.sv
// Synchronizes the asynchronous counter bus and strobes once per value that has
// stayed stable for STABLE_CYC synchronized samples.
module count_bus_sync
  import ripple_sampler_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int STABLE_CYC = STABLE_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_q,
  output logic [WIDTH-1:0] o_stable_val,
  output logic             o_stable_stb
);

  localparam int HOLD_W = (STABLE_CYC < 1) ? 1 : $clog2(STABLE_CYC + 1);
  localparam int RUN_W  = HOLD_W + 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(STABLE_CYC);

  logic [WIDTH-1:0]  r_s1, r_s2, r_s3;
  logic [HOLD_W-1:0] r_hold;
  logic              w_eq;
  logic [RUN_W-1:0]  w_run;

  // w_run = number of consecutive samples s2 has shown its current value;
  // the hold counter saturates so a long-stable value strobes exactly once.
  assign w_eq         = (r_s2 == r_s3);
  assign w_run        = w_eq ? ({1'b0, r_hold} + RUN_W'(2)) : RUN_W'(1);
  assign o_stable_stb = (w_run == RUN_W'(STABLE_CYC));
  assign o_stable_val = r_s2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_s3   <= '0;
      r_hold <= '0;
    end else begin
      r_s1 <= i_q;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      if (!w_eq)
        r_hold <= '0;
      else if (r_hold != HOLD_MAX)
        r_hold <= r_hold + 1'b1;
    end
  end

endmodule

// File: rtl/ripple_count_sampler.sv
// Ripple down-counter sampler: accepts only stable codes, extends the count with
// an underflow counter. Optional skipped-step checker: RIPPLE_SAMPLER_STEP_CHECK_EN.
module ripple_count_sampler
  import ripple_sampler_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int STABLE_CYC = STABLE_CYC_DEF,
  parameter int WRAP_W     = WRAP_W_DEF
) (
  input logic                   clk,
  input logic                   rst_n,
  ripple_count_sampler_if.slave bus
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  state_t              r_state;
  logic [WIDTH-1:0]    r_count;
  logic                r_valid;
  logic [WRAP_W-1:0]   r_wraps;
  logic                r_wrap_pulse;
  logic [WIDTH-1:0]    w_stable_val;
  logic                w_stable_stb;

  count_bus_sync #(
    .WIDTH      (WIDTH),
    .STABLE_CYC (STABLE_CYC)
  ) u_sync (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_q          (bus.q_in),
    .o_stable_val (w_stable_val),
    .o_stable_stb (w_stable_stb)
  );

  // Dropping en wins over a same-edge acceptance; wraps survive re-enable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_count      <= '0;
      r_valid      <= 1'b0;
      r_wraps      <= '0;
      r_wrap_pulse <= 1'b0;
    end else begin
      r_wrap_pulse <= 1'b0;
      if (!bus.en) begin
        r_state <= IDLE;
        r_valid <= 1'b0;
      end else begin
        case (r_state)
          IDLE: r_state <= ACQUIRE;
          ACQUIRE: begin
            if (w_stable_stb) begin
              r_count <= w_stable_val;
              r_valid <= 1'b1;
              r_state <= TRACK;
            end
          end
          TRACK: begin
            if (w_stable_stb) begin
              r_count <= w_stable_val;
              if (r_count == '0 && w_stable_val == CNT_MAX) begin
                r_wrap_pulse <= 1'b1;
                r_wraps      <= r_wraps + 1'b1;
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.count       = r_count;
  assign bus.count_valid = r_valid;
  assign bus.ext_count   = {r_wraps, r_count};
  assign bus.wrap_pulse  = r_wrap_pulse;

`ifdef RIPPLE_SAMPLER_STEP_CHECK_EN
  logic                 r_step_err;
  logic [ERR_CNT_W-1:0] r_err_cnt;
  logic [WIDTH-1:0]     w_dec;
  logic                 w_bad_step;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] x);
    return (x == '1) ? x : x + 1'b1;
  endfunction

  // 0 -> max is a legal decrement, so a wrap never counts as a step error.
  assign w_dec      = r_count - WIDTH'(1);
  assign w_bad_step = bus.en && (r_state == TRACK) && w_stable_stb &&
                      (w_stable_val != w_dec) && (w_stable_val != r_count);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_step_err <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      r_step_err <= w_bad_step;
      if (w_bad_step)
        r_err_cnt <= sat_inc(r_err_cnt);
    end
  end

  assign bus.step_err = r_step_err;
  assign bus.err_cnt  = r_err_cnt;
`else
  assign bus.step_err = 1'b0;
  assign bus.err_cnt  = '0;
`endif

endmodule

// File: doc/ripple_count_sampler.md
# ripple_count_sampler

Downstream consumer of the asynchronous 4-bit ripple down counter. Samples the counter's asynchronous `q` bus into the system clock domain and rejects ripple transients by requiring a stable value for a configurable number of cycles. Tracks underflow wrap-around (0 → 15) to extend the count, and can optionally flag skipped steps. Its outputs feed synchronous logic that must never observe an intermediate ripple code.

## Interface
Parameters:
- `WIDTH`, 4, width of the sampled counter bus.
- `STABLE_CYC`, 2, consecutive equal synchronized samples required to accept a value (≥1).
- `WRAP_W`, 8, width of the wrap (underflow) extension counter.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `en`  in  1  sampling enable.
- `q_in`  in  WIDTH  raw ripple counter output, asynchronous to `clk`.
- `count`  out  WIDTH  last accepted stable count.
- `count_valid`  out  1  `count` holds an accepted value since the last enable or reset.
- `ext_count`  out  WRAP_W+WIDTH  `{wraps, count}`.
- `wrap_pulse`  out  1  one-cycle pulse on an accepted 0 → 2^WIDTH-1 transition.
- `step_err`  out  1  one-cycle pulse on an accepted non-decrement (macro-gated).
- `err_cnt`  out  8  saturating count of `step_err` events (macro-gated).

## Operation
- Front end: a 2-flop synchronizer per bit (`s1`, `s2`), plus `s3` holding the previous `s2`. A hold counter increments while `s2 == s3` and clears otherwise. A value is accepted once it has been held for `STABLE_CYC` samples; each stable value is accepted exactly once.
- FSM states:
  - IDLE: entered on reset or when `en = 0`. `count_valid = 0`. `count` and `wraps` hold their values.
  - ACQUIRE: entered from IDLE when `en = 1`. The first accepted value loads `count`, sets `count_valid = 1`, and moves to TRACK. No wrap or step evaluation occurs on this first value.
  - TRACK: each accepted value `v` loads `count`.
    - If the previous `count` is 0 and `v` is 2^WIDTH-1: assert `wrap_pulse` and set `wraps <= wraps + 1` (mod 2^WRAP_W).
    - If `v != count - 1` (mod 2^WIDTH) and `v != count`: step error.
- `en` falls → IDLE on the next edge. An acceptance on that same edge is discarded.
- `wraps` clears only on reset. Re-enable does not clear it.
- Wrap and step error are mutually exclusive, because 0 → 15 is a legal decrement.

## Timing
- Reset values: `count = 0`, `count_valid = 0`, `ext_count = 0`, `wrap_pulse = 0`, `step_err = 0`, `err_cnt = 0`. `s1`/`s2`/`s3` and the hold counter are also cleared; state = IDLE.
- Reset asserted mid-operation clears all of the above at that edge, including any in-flight acceptance.
- Latency: let E0 be the first edge at which `q_in` is stable into `s1`. `count` updates at edge E0+1+`STABLE_CYC` (E0+3 at the default). `wrap_pulse` and `step_err` are registered in the same cycle that `count` updates.
- Glitch rejection: any `q_in` value held for fewer than `STABLE_CYC` synchronized samples is never accepted.
- Operating constraint: `clk` frequency ≥ (`STABLE_CYC`+2) × counter toggle rate. Faster counting can cause missed steps, which `step_err` reports when enabled.

## Configuration
- Macro `RIPPLE_SAMPLER_STEP_CHECK_EN`.
- Defined: step-error compare, the `step_err` pulse, and the 8-bit saturating `err_cnt` (sticks at 255) are built.
- Undefined: both ports remain but are tied to 0. No compare logic is built.

## Structure
- Package `ripple_sampler_pkg`:
  - state enum (IDLE, ACQUIRE, TRACK);
  - default constants `WIDTH_DEF = 4`, `STABLE_CYC_DEF = 2`, `WRAP_W_DEF = 8`, `ERR_CNT_W = 8`.
- Sub-module `count_bus_sync`: `s1`/`s2`/`s3`, the hold counter, and acceptance logic. It outputs `stable_val[WIDTH]` and a one-cycle `stable_stb`.
- The top level holds the FSM, wrap, and step-error logic.

## Test plan
- Reset then `en = 1`; `q_in` held at 4'hA → `count = A`, `count_valid = 1` at E0+3; no `wrap_pulse` or `step_err`.
- Clean decrement 3,2,1,0,F, each held 8 clocks → `count` follows. A single `wrap_pulse` fires on F; `ext_count` = {8'h01, 4'hF}.
- `q_in` 1000 → 0111 via a 1-cycle transient 0110 → 0110 is never accepted; `count` goes 8 → 7 with `step_err = 0`.
- With the macro defined: jump 9 → 6 → `step_err` pulses once and `err_cnt = 1`. Without the macro: `step_err` stays 0 and `err_cnt` stays 0.
- `en` dropped after `wraps = 2`, `q_in` changed, `en` re-asserted → `count_valid` goes 0 then 1. The first accepted value causes no wrap or error, and `wraps` stays 2.
- `rst_n = 0` for one edge mid-sequence → all outputs are 0 at the next cycle; the FSM is in IDLE.
